// File: rtl/hack_alu_pkg.sv
// Shared constants for the Hack ALU and the arbiter that time-shares it.
package hack_alu_pkg;

    localparam int CTRL_W = 6;

    typedef logic [CTRL_W-1:0] alu_ctrl_t;

    localparam int F_ZX = 5;
    localparam int F_NX = 4;
    localparam int F_ZY = 3;
    localparam int F_NY = 2;
    localparam int F_F  = 1;
    localparam int F_NO = 0;

    localparam alu_ctrl_t C_ZERO   = 6'b101010;
    localparam alu_ctrl_t C_ONE    = 6'b111111;
    localparam alu_ctrl_t C_NEG1   = 6'b111010;
    localparam alu_ctrl_t C_X      = 6'b001100;
    localparam alu_ctrl_t C_Y      = 6'b110000;
    localparam alu_ctrl_t C_NOTX   = 6'b001101;
    localparam alu_ctrl_t C_XPLUSY = 6'b000010;
    localparam alu_ctrl_t C_XMINUSY= 6'b010011;
    localparam alu_ctrl_t C_XANDY  = 6'b000000;
    localparam alu_ctrl_t C_XORY   = 6'b010101;

endpackage

// File: rtl/hack_alu.sv
// Combinational 16-bit Hack ALU with zero and negative flags.
module hack_alu
    import hack_alu_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  alu_ctrl_t   c,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x0, x1, y0, y1, f, o;

    assign x0  = c[F_ZX] ? 16'h0000 : x;
    assign x1  = c[F_NX] ? ~x0 : x0;
    assign y0  = c[F_ZY] ? 16'h0000 : y;
    assign y1  = c[F_NY] ? ~y0 : y0;
    assign f   = c[F_F] ? (x1 + y1) : (x1 & y1);
    assign o   = c[F_NO] ? ~f : f;

    assign out = o;
    assign zr  = (o == 16'h0000);
    assign ng  = o[15];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: searches last+1, last+2, ... and grants the first request.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_v_o
);

    int   j;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_v_o   = 1'b0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found        = 1'b1;
                gnt_o[j]     = 1'b1;
                gnt_idx_o    = IW'(j);
                gnt_v_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hack_alu_arbiter.sv
// Shares one Hack ALU between NREQ requesters: round-robin grant into a
// single stage-1 register, result parked in a per-requester response slot.
module hack_alu_arbiter
    import hack_alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*CTRL_W-1:0]  req_ctrl,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [NREQ*WIDTH-1:0]   rsp_data,
    output logic [NREQ-1:0]         rsp_zr,
    output logic [NREQ-1:0]         rsp_ng
);

    localparam int IW = $clog2(NREQ);

    if (WIDTH != 16 || NREQ < 2 || NREQ > 4) begin : g_cfg_err
        $error("hack_alu_arbiter: unsupported NREQ/WIDTH");
    end

    logic                  s1_v_q, s1_v_d;
    logic [IW-1:0]         s1_id_q, s1_id_d;
    logic [WIDTH-1:0]      s1_a_q, s1_a_d;
    logic [WIDTH-1:0]      s1_b_q, s1_b_d;
    alu_ctrl_t             s1_c_q, s1_c_d;
    logic [IW-1:0]         last_q, last_d;

    logic [NREQ-1:0]       rsp_v_q, rsp_v_d;
    logic [NREQ*WIDTH-1:0] data_q, data_d;
    logic [NREQ-1:0]       zr_q, zr_d;
    logic [NREQ-1:0]       ng_q, ng_d;

    logic [NREQ-1:0]       elig;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_v;

    logic [15:0]           alu_out;
    logic                  alu_zr;
    logic                  alu_ng;

    // One op per requester in flight; a full slot may take a new op only while draining.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i]
                    && !(s1_v_q && s1_id_q == IW'(i))
                    && (!rsp_v_q[i] || rsp_ready[i]);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i     (elig),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_v_o   (gnt_v)
    );

    assign req_ready = rst_n ? gnt : '0;

    hack_alu u_alu (
        .x   (s1_a_q),
        .y   (s1_b_q),
        .c   (s1_c_q),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_comb begin
        s1_v_d  = gnt_v;
        s1_id_d = s1_id_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_c_d  = s1_c_q;
        last_d  = last_q;
        if (gnt_v) begin
            s1_id_d = gnt_idx;
            s1_a_d  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            s1_b_d  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            s1_c_d  = req_ctrl[int'(gnt_idx)*CTRL_W +: CTRL_W];
            last_d  = gnt_idx;
        end
    end

    // The stage-1 write into a slot wins over a same-edge consume.
    always_comb begin
        rsp_v_d = rsp_v_q & ~rsp_ready;
        data_d  = data_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        if (s1_v_q) begin
            rsp_v_d[s1_id_q]                     = 1'b1;
            data_d[int'(s1_id_q)*WIDTH +: WIDTH] = alu_out;
            zr_d[s1_id_q]                        = alu_zr;
            ng_d[s1_id_q]                        = alu_ng;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_id_q <= '0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_c_q  <= '0;
            last_q  <= IW'(NREQ-1);
            rsp_v_q <= '0;
            data_q  <= '0;
            zr_q    <= '0;
            ng_q    <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_id_q <= s1_id_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_c_q  <= s1_c_d;
            last_q  <= last_d;
            rsp_v_q <= rsp_v_d;
            data_q  <= data_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
        end
    end

    assign rsp_valid = rsp_v_q;
    assign rsp_data  = data_q;
    assign rsp_zr    = zr_q;
    assign rsp_ng    = ng_q;

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Bench for hack_alu_arbiter: vector table, directed corner sequences,
// and random traffic against a transaction-level reference model.
module tb_hack_alu_arbiter;
    import hack_alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_ctrl;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_zr;
    logic [1:0]  rsp_ng;

    int checks;
    int failures;

    hack_alu_arbiter #(
        .NREQ  (2),
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        alu_ctrl_t   c;
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] out;
    } flight_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [5:0] c);
        logic [15:0] x, y, r;
        x = c[5] ? 16'd0 : a;
        if (c[4]) x = 16'hFFFF - x;
        y = c[3] ? 16'd0 : b;
        if (c[2]) y = 16'hFFFF - y;
        r = c[1] ? 16'((32'(x) + 32'(y)) % 65536) : (x & y);
        if (c[0]) r = 16'hFFFF - r;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic run_table();
        logic [1:0] onehot;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            onehot            = 2'b00;
            onehot[vecs[n].id] = 1'b1;
            req_valid         = onehot;
            rsp_ready         = 2'b00;
            req_a[vecs[n].id*16 +: 16]   = vecs[n].a;
            req_b[vecs[n].id*16 +: 16]   = vecs[n].b;
            req_ctrl[vecs[n].id*6 +: 6]  = vecs[n].c;
            #1 chk("tbl_ready", req_ready, onehot);
            @(negedge clk);
            req_valid = 2'b00;
            chk("tbl_latency", rsp_valid, 2'b00);
            @(negedge clk);
            chk("tbl_valid", rsp_valid, onehot);
            chk("tbl_data", rsp_data[vecs[n].id*16 +: 16], vecs[n].out);
            chk("tbl_zr", rsp_zr[vecs[n].id], vecs[n].zr);
            chk("tbl_ng", rsp_ng[vecs[n].id], vecs[n].ng);
            rsp_ready = onehot;
            @(negedge clk);
            rsp_ready = 2'b00;
            chk("tbl_consumed", rsp_valid, 2'b00);
        end
    endtask

    task automatic run_random(input int ncyc);
        flight_t     fq[$];
        flight_t     f;
        logic [1:0]  m_rv;
        logic [15:0] m_rd[2];
        int          last;
        int          g;
        int          j;
        logic [1:0]  exp_rdy;
        do_reset();
        fq.delete();
        m_rv = 2'b00;
        last = 1;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_ctrl  = 12'($urandom);
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            for (int k = 1; k <= 2; k++) begin
                j = (last + k) % 2;
                if (g < 0 && req_valid[j]
                    && !(fq.size() > 0 && fq[0].id == j)
                    && (!m_rv[j] || rsp_ready[j]))
                    g = j;
            end
            exp_rdy = 2'b00;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_valid", rsp_valid, m_rv);
            for (int i = 0; i < 2; i++) begin
                if (m_rv[i]) begin
                    chk("rnd_data", rsp_data[i*16 +: 16], m_rd[i]);
                    chk("rnd_zr", rsp_zr[i], m_rd[i] == 16'd0);
                    chk("rnd_ng", rsp_ng[i], m_rd[i] >= 16'h8000);
                end
            end
            @(posedge clk);
            for (int i = 0; i < 2; i++)
                if (m_rv[i] && rsp_ready[i]) m_rv[i] = 1'b0;
            if (fq.size() > 0) begin
                f = fq.pop_front();
                m_rv[f.id] = 1'b1;
                m_rd[f.id] = f.out;
            end
            if (g >= 0) begin
                f.id  = g;
                f.out = ref_alu(req_a[g*16 +: 16], req_b[g*16 +: 16],
                                req_ctrl[g*6 +: 6]);
                fq.push_back(f);
                last = g;
            end
        end
        drain();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 2'b00;

        vecs[0] = '{0, 16'h1100, 16'h1011, C_NOTX,    16'hEEFF, 1'b0, 1'b1};
        vecs[1] = '{1, 16'h0003, 16'h0003, C_XMINUSY, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{0, 16'h7FFF, 16'h0001, C_XPLUSY,  16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1, 16'h1234, 16'h5678, C_ZERO,    16'h0000, 1'b1, 1'b0};
        vecs[4] = '{0, 16'h1234, 16'h5678, C_ONE,     16'h0001, 1'b0, 1'b0};
        vecs[5] = '{1, 16'h1234, 16'h5678, C_NEG1,    16'hFFFF, 1'b0, 1'b1};
        vecs[6] = '{0, 16'hF0F0, 16'hFF00, C_XANDY,   16'hF000, 1'b0, 1'b1};
        vecs[7] = '{1, 16'h00F0, 16'h0F00, C_XORY,    16'h0FF0, 1'b0, 1'b0};
        vecs[8] = '{0, 16'hAAAA, 16'h1234, C_Y,       16'h1234, 1'b0, 1'b0};
        vecs[9] = '{1, 16'h8001, 16'h5555, C_X,       16'h8001, 1'b0, 1'b1};

        // Reset state, with requests already pending.
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_valid", rsp_valid, 2'b00);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_zr", rsp_zr, 2'b00);
        chk("rst_ng", rsp_ng, 2'b00);

        do_reset();
        run_table();

        // Contention after reset: strict alternation starting with req0.
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1 chk("contend", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
        drain();

        // Backpressure on slot 0 while req1 keeps flowing.
        do_reset();
        req_a[15:0]   = 16'h0005;
        req_b[15:0]   = 16'h0003;
        req_ctrl[5:0] = C_XPLUSY;
        rsp_ready     = 2'b10;
        req_valid     = 2'b11;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c == 1)
                chk("bp_ready", req_ready, 2'b01);
            else
                chk("bp_ready", req_ready, (c % 2 == 0) ? 2'b10 : 2'b00);
            if (c >= 3) begin
                chk("bp_hold_v", rsp_valid[0], 1'b1);
                chk("bp_hold_d", rsp_data[15:0], 16'h0008);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b11;
        #1 chk("bp_release", req_ready, 2'b01);
        @(negedge clk);
        drain();

        // Reset while an op sits in stage 1.
        do_reset();
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1 chk("rm_first", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rm_slot1", rsp_valid, 2'b10);
        req_valid = 2'b01;
        #1 chk("rm_grant0", req_ready, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rm_clear", rsp_valid, 2'b00);
        chk("rm_ready", req_ready, 2'b00);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1 chk("rm_nostale", rsp_valid, 2'b00);
            @(negedge clk);
        end
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1 chk("rm_prio", req_ready, 2'b01);
        @(negedge clk);
        drain();

        run_random(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
